wb_uart_debug_master: RTL

// - UART-driven Wishbone bus master, so a host can peek/poke the SoC bus without the CPU.
// - Attaches as an extra master port on wishbone_crossbar, alongside cpu0.
// - Receives 8N1 command frames on uart_rx, runs one classic single Wishbone transfer per frame, and replies on uart_tx.

---
 rtl/wb_uart_debug_master.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_uart_debug_master.sv
// wb_uart_debug_master: host-facing UART command port that runs one classic
// single Wishbone transfer per received frame and answers with a status byte
// (plus read data for a successful read).
module wb_uart_debug_master #(
  parameter int CLKS_PER_BIT  = 260,
  parameter int WB_TIMEOUT    = 1024,
  parameter int FRAME_TIMEOUT = 3000000,
  parameter int TAG_WIDTH     = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  output logic                 wb_cyc,
  output logic                 wb_stb,
  output logic                 wb_we,
  output logic [TAG_WIDTH-1:0] wb_tag,
  output logic [3:0]           wb_sel,
  output logic [31:0]          wb_adr,
  output logic [31:0]          wb_mosi,
  input  logic [31:0]          wb_miso,
  input  logic                 wb_ack,
  input  logic                 wb_err,
  output logic                 busy
);

  localparam int BIT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BUS_W = $clog2(WB_TIMEOUT + 1);
  localparam int FRM_W = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BUS_W-1:0] BUS_LAST = BUS_W'(WB_TIMEOUT - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_TIMEOUT - 1);
  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_ADR   = 3'd1,
    GET_DAT   = 3'd2,
    BUS       = 3'd3,
    SEND_STAT = 3'd4,
    SEND_DAT  = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic               rx_meta_r, rx_sync_r, rx_prev_r, rx_busy_r, rx_valid_r;
  logic [BIT_W-1:0]   rx_cnt_r;
  logic [3:0]         rx_idx_r;
  logic [7:0]         rx_byte_r;
  logic               tx_busy_r;
  logic [BIT_W-1:0]   tx_cnt_r;
  logic [3:0]         tx_idx_r;
  logic [9:0]         tx_shift_r;
  logic               tx_last_s, tx_ready_s, tx_load_s;
  logic [7:0]         tx_byte_s;
  logic               write_r, write_s, ok_r, ok_s;
  logic [1:0]         cnt_r, cnt_s;
  logic [31:0]        rdata_r, rdata_s;
  logic [FRM_W-1:0]   frame_cnt_r, frame_cnt_s;
  logic [BUS_W-1:0]   bus_cnt_r, bus_cnt_s;
  logic               cyc_s, stb_s, we_s;
  logic [3:0]         sel_s;
  logic [31:0]        adr_s, mosi_s;

  assign wb_tag     = {TAG_WIDTH{1'b0}};
  assign uart_tx    = tx_shift_r[0];
  // The stop bit's last cycle: a new byte loaded here follows with no idle gap.
  assign tx_last_s  = tx_busy_r && (tx_idx_r == 4'd9) && (tx_cnt_r == BIT_W'(0));
  assign tx_ready_s = !tx_busy_r || tx_last_s;

  // RX: synchronise, detect start edge, sample each bit at its centre, LSB first.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      rx_prev_r  <= 1'b1;
      rx_busy_r  <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_cnt_r   <= BIT_W'(0);
      rx_idx_r   <= 4'd0;
      rx_byte_r  <= 8'h00;
    end else begin
      rx_meta_r  <= uart_rx;
      rx_sync_r  <= rx_meta_r;
      rx_prev_r  <= rx_sync_r;
      rx_valid_r <= 1'b0;
      if (!rx_busy_r) begin
        if (rx_prev_r && !rx_sync_r) begin
          rx_busy_r <= 1'b1;
          rx_cnt_r  <= BIT_HALF;
          rx_idx_r  <= 4'd0;
        end
      end else if (rx_cnt_r != BIT_W'(0)) begin
        rx_cnt_r <= rx_cnt_r - BIT_W'(1);
      end else begin
        rx_cnt_r <= BIT_LAST;
        rx_idx_r <= rx_idx_r + 4'd1;
        if (rx_idx_r == 4'd0) begin
          // Line back high at mid start bit: a glitch, not a byte.
          if (rx_sync_r) rx_busy_r <= 1'b0;
        end else if (rx_idx_r == 4'd9) begin
          // A low stop bit is a framing error; the byte is silently dropped.
          rx_busy_r  <= 1'b0;
          rx_valid_r <= rx_sync_r;
        end else begin
          rx_byte_r <= {rx_sync_r, rx_byte_r[7:1]};
        end
      end
    end
  end

  // TX: 10-bit shifter (start, data LSB first, stop), each bit held one bit time.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      tx_shift_r <= 10'h3FF;
      tx_busy_r  <= 1'b0;
      tx_cnt_r   <= BIT_W'(0);
      tx_idx_r   <= 4'd0;
    end else if (tx_load_s) begin
      tx_shift_r <= {1'b1, tx_byte_s, 1'b0};
      tx_busy_r  <= 1'b1;
      tx_cnt_r   <= BIT_LAST;
      tx_idx_r   <= 4'd0;
    end else if (tx_busy_r) begin
      if (tx_cnt_r != BIT_W'(0)) begin
        tx_cnt_r <= tx_cnt_r - BIT_W'(1);
      end else if (tx_idx_r == 4'd9) begin
        tx_busy_r <= 1'b0;
      end else begin
        tx_shift_r <= {1'b1, tx_shift_r[9:1]};
        tx_idx_r   <= tx_idx_r + 4'd1;
        tx_cnt_r   <= BIT_LAST;
      end
    end
  end

  // Control: frame parsing, bus transfer and reply sequencing (next-state logic).
  always_comb begin
    state_s     = state_r;
    write_s     = write_r;
    ok_s        = ok_r;
    cnt_s       = cnt_r;
    rdata_s     = rdata_r;
    frame_cnt_s = frame_cnt_r;
    bus_cnt_s   = bus_cnt_r;
    cyc_s       = wb_cyc;
    stb_s       = wb_stb;
    we_s        = wb_we;
    sel_s       = wb_sel;
    adr_s       = wb_adr;
    mosi_s      = wb_mosi;
    tx_load_s   = 1'b0;
    tx_byte_s   = 8'h00;
    case (state_r)
      IDLE: begin
        cnt_s       = 2'd0;
        frame_cnt_s = FRM_W'(0);
        if (rx_valid_r && ((rx_byte_r == CMD_WR) || (rx_byte_r == CMD_RD))) begin
          state_s = GET_ADR;
          write_s = (rx_byte_r == CMD_WR);
        end else begin
          state_s = IDLE;
        end
      end
      GET_ADR: begin
        if (rx_valid_r) begin
          adr_s       = {wb_adr[23:0], rx_byte_r};
          frame_cnt_s = FRM_W'(0);
          if (cnt_r == 2'd3) begin
            cnt_s = 2'd0;
            if (write_r) begin
              state_s = GET_DAT;
            end else begin
              state_s   = BUS;
              cyc_s     = 1'b1;
              stb_s     = 1'b1;
              we_s      = 1'b0;
              sel_s     = 4'hF;
              bus_cnt_s = BUS_W'(0);
            end
          end else begin
            cnt_s = cnt_r + 2'd1;
          end
        end else if (frame_cnt_r == FRM_LAST) begin
          state_s = IDLE;
        end else begin
          frame_cnt_s = frame_cnt_r + FRM_W'(1);
        end
      end
      GET_DAT: begin
        if (rx_valid_r) begin
          mosi_s      = {wb_mosi[23:0], rx_byte_r};
          frame_cnt_s = FRM_W'(0);
          if (cnt_r == 2'd3) begin
            cnt_s     = 2'd0;
            state_s   = BUS;
            cyc_s     = 1'b1;
            stb_s     = 1'b1;
            we_s      = 1'b1;
            sel_s     = 4'hF;
            bus_cnt_s = BUS_W'(0);
          end else begin
            cnt_s = cnt_r + 2'd1;
          end
        end else if (frame_cnt_r == FRM_LAST) begin
          state_s = IDLE;
        end else begin
          frame_cnt_s = frame_cnt_r + FRM_W'(1);
        end
      end
      BUS: begin
        if (wb_ack || wb_err) begin
          // err wins when both are high.
          cyc_s   = 1'b0;
          stb_s   = 1'b0;
          we_s    = 1'b0;
          sel_s   = 4'h0;
          ok_s    = !wb_err;
          rdata_s = wb_miso;
          state_s = SEND_STAT;
        end else if (bus_cnt_r == BUS_LAST) begin
          cyc_s   = 1'b0;
          stb_s   = 1'b0;
          we_s    = 1'b0;
          sel_s   = 4'h0;
          ok_s    = 1'b0;
          state_s = SEND_STAT;
        end else begin
          bus_cnt_s = bus_cnt_r + BUS_W'(1);
        end
      end
      SEND_STAT: begin
        if (tx_ready_s) begin
          tx_load_s = 1'b1;
          tx_byte_s = ok_r ? RSP_OK : RSP_ERR;
          cnt_s     = 2'd0;
          state_s   = (ok_r && !write_r) ? SEND_DAT : IDLE;
        end else begin
          state_s = SEND_STAT;
        end
      end
      SEND_DAT: begin
        if (tx_ready_s) begin
          tx_load_s = 1'b1;
          tx_byte_s = rdata_r[31:24];
          rdata_s   = {rdata_r[23:0], 8'h00};
          if (cnt_r == 2'd3) begin
            cnt_s   = 2'd0;
            state_s = IDLE;
          end else begin
            cnt_s = cnt_r + 2'd1;
          end
        end else begin
          state_s = SEND_DAT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control: state register and registered bus/busy outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r     <= IDLE;
      write_r     <= 1'b0;
      ok_r        <= 1'b0;
      cnt_r       <= 2'd0;
      rdata_r     <= 32'h0;
      frame_cnt_r <= FRM_W'(0);
      bus_cnt_r   <= BUS_W'(0);
      wb_cyc      <= 1'b0;
      wb_stb      <= 1'b0;
      wb_we       <= 1'b0;
      wb_sel      <= 4'h0;
      wb_adr      <= 32'h0;
      wb_mosi     <= 32'h0;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_s;
      write_r     <= write_s;
      ok_r        <= ok_s;
      cnt_r       <= cnt_s;
      rdata_r     <= rdata_s;
      frame_cnt_r <= frame_cnt_s;
      bus_cnt_r   <= bus_cnt_s;
      wb_cyc      <= cyc_s;
      wb_stb      <= stb_s;
      wb_we       <= we_s;
      wb_sel      <= sel_s;
      wb_adr      <= adr_s;
      wb_mosi     <= mosi_s;
      busy        <= (state_s != IDLE) || tx_load_s || (tx_busy_r && !tx_last_s);
    end
  end

endmodule
